// File: rtl/serial_add_sub_unit_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Holds the FSM state enum, mode encodings and the slice-counter width helper.
package add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // A single-digit operation still needs a one-bit counter to keep the datapath regular.
   function automatic int cntWidth(input int n, input int k);
      int digits;
      digits = n / k;
      return (digits <= 1) ? 1 : $clog2(digits);
   endfunction

endpackage

// File: rtl/serial_add_sub_unit_if.sv
// Request/result bundle for serial_add_sub_unit.
// The master drives the operands and start; the slave returns the handshake status and the result flags.
interface serial_add_sub_unit_if #(
   parameter int N = 16
);
   logic         start;
   logic         mode;
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         bIn;
   logic         ready;
   logic         busy;
   logic         done;
   logic [N-1:0] z;
   logic         b;
   logic         v;

   modport master (
      output start, mode, x, y, bIn,
      input  ready, busy, done, z, b, v
   );

   modport slave (
      input  start, mode, x, y, bIn,
      output ready, busy, done, z, b, v
   );
endinterface

// File: rtl/serial_add_sub_unit_digit_add_sub.sv
// Combinational K-bit slice: ripple of full adders or full subtractors.
// The subtract path uses the classic full-subtractor borrow equation, bit by bit.
module digit_add_sub
   import add_sub_pkg::*;
#(
   parameter int K = 4
) (
   input  logic [K-1:0] a_i,
   input  logic [K-1:0] b_i,
   input  logic         chain_i,
   input  logic         mode_i,
   output logic [K-1:0] d_o,
   output logic         chain_o
);

   logic [K:0] chain;

   // chain[i] is the carry (add) or borrow (sub) flowing into bit i of the digit.
   always_comb begin
      chain    = '0;
      d_o      = '0;
      chain[0] = chain_i;
      for (int i = 0; i < K; i++) begin
         d_o[i] = a_i[i] ^ b_i[i] ^ chain[i];
         if (mode_i == MODE_ADD) begin
            chain[i+1] = (a_i[i] & b_i[i]) | (chain[i] & (a_i[i] ^ b_i[i]));
         end else begin
            chain[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & chain[i]);
         end
      end
      chain_o = chain[K];
   end

endmodule

// File: rtl/serial_add_sub_unit.sv
// Digit-serial N-bit add/subtract unit processing K bits per clock with start/ready/done handshake.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp z to the signed range whenever v is set.
module serial_add_sub_unit
   import add_sub_pkg::*;
#(
   parameter int N = 16,
   parameter int K = 4
) (
   input logic                  clk,
   input logic                  rst,
   serial_add_sub_unit_if.slave bus
);

   localparam int             DIGITS = N / K;
   localparam int             CW     = cntWidth(N, K);
   localparam logic [CW-1:0]  LAST   = CW'(DIGITS - 1);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   opX_q, opY_q, acc_q, z_q;
   logic           mode_q, chain_q, b_q, v_q;

   logic           accept, lastDigit;
   logic [K-1:0]   xDigit, yDigit, digit;
   logic           chainOut, vRaw;
   logic [N-1:0]   accMerged, zLoad;

   assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
   assign lastDigit = (cnt_q == LAST);

   // Current digit of each latched operand, and the accumulator with this cycle's digit patched in.
   always_comb begin
      xDigit    = opX_q[int'(cnt_q)*K +: K];
      yDigit    = opY_q[int'(cnt_q)*K +: K];
      accMerged = acc_q;
      accMerged[int'(cnt_q)*K +: K] = digit;
   end

   digit_add_sub #(.K(K)) uSlice (
      .a_i     (xDigit),
      .b_i     (yDigit),
      .chain_i (chain_q),
      .mode_i  (mode_q),
      .d_o     (digit),
      .chain_o (chainOut)
   );

   // Signed overflow judged on the full result that will be loaded on the final RUN cycle.
   always_comb begin
      if (mode_q == MODE_ADD) begin
         vRaw = ~(opX_q[N-1] ^ opY_q[N-1]) & (accMerged[N-1] ^ opX_q[N-1]);
      end else begin
         vRaw = (opX_q[N-1] ^ opY_q[N-1]) & (accMerged[N-1] ^ opX_q[N-1]);
      end
`ifdef SERIAL_ADD_SUB_SATURATE_EN
      if (vRaw) begin
         zLoad = opX_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else begin
         zLoad = accMerged;
      end
`else
      zLoad = accMerged;
`endif
   end

   // State and datapath registers; reset wins over any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opX_q   <= '0;
         opY_q   <= '0;
         mode_q  <= MODE_SUB;
         chain_q <= 1'b0;
         acc_q   <= '0;
         z_q     <= '0;
         b_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            opX_q   <= bus.x;
            opY_q   <= bus.y;
            mode_q  <= bus.mode;
            chain_q <= bus.bIn;
            cnt_q   <= '0;
            acc_q   <= '0;
         end else if (state_q == RUN) begin
            acc_q   <= accMerged;
            chain_q <= chainOut;
            cnt_q   <= cnt_q + CW'(1);
            if (lastDigit) begin
               z_q <= zLoad;
               b_q <= chainOut;
               v_q <= vRaw;
            end
         end
      end
   end

   // Next-state logic; DONE can chain straight into another RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (lastDigit) state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state_q == IDLE) || (state_q == DONE);
      bus.busy  = (state_q == RUN);
      bus.done  = (state_q == DONE);
      bus.z     = z_q;
      bus.b     = b_q;
      bus.v     = v_q;
   end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed self-checking bench for serial_add_sub_unit at N=16 with K=4, K=1 and K=16 instances.
// Expected values are hand-computed; the clamp expectations follow SERIAL_ADD_SUB_SATURATE_EN.
module tb_serial_add_sub_unit;
   import add_sub_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   curK     = 4;

`ifdef SERIAL_ADD_SUB_SATURATE_EN
   localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
   localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
`else
   localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
   localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
`endif

   always #5 clk = ~clk;

   serial_add_sub_unit_if #(.N(16)) ifA ();
   serial_add_sub_unit_if #(.N(16)) ifB ();
   serial_add_sub_unit_if #(.N(16)) ifC ();

   serial_add_sub_unit #(.N(16), .K(4))  dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
   serial_add_sub_unit #(.N(16), .K(1))  dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
   serial_add_sub_unit #(.N(16), .K(16)) dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

   function automatic int kOf(input int sel);
      case (sel)
         0:       return 4;
         1:       return 1;
         default: return 16;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL K%0d %s observed=0x%0h expected=0x%0h", curK, tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic st, input logic md,
                                input logic [15:0] xv, input logic [15:0] yv, input logic bi);
      case (sel)
         0: begin ifA.start = st; ifA.mode = md; ifA.x = xv; ifA.y = yv; ifA.bIn = bi; end
         1: begin ifB.start = st; ifB.mode = md; ifB.x = xv; ifB.y = yv; ifB.bIn = bi; end
         default: begin ifC.start = st; ifC.mode = md; ifC.x = xv; ifC.y = yv; ifC.bIn = bi; end
      endcase
   endtask

   task automatic getOut(input int sel, output logic rd, output logic bs, output logic dn,
                         output logic [15:0] zz, output logic bb, output logic vv);
      case (sel)
         0: begin rd = ifA.ready; bs = ifA.busy; dn = ifA.done; zz = ifA.z; bb = ifA.b; vv = ifA.v; end
         1: begin rd = ifB.ready; bs = ifB.busy; dn = ifB.done; zz = ifB.z; bb = ifB.b; vv = ifB.v; end
         default: begin rd = ifC.ready; bs = ifC.busy; dn = ifC.done; zz = ifC.z; bb = ifC.b; vv = ifC.v; end
      endcase
   endtask

   // Issue one operation from the current negedge and follow it to its done pulse.
   task automatic runOp(input int sel, input string tag, input logic md,
                        input logic [15:0] xv, input logic [15:0] yv, input logic bi,
                        input logic [15:0] ez, input logic eb, input logic ev, input bit poke);
      int cycles, busyCnt, L;
      logic rd, bs, dn, bb, vv;
      logic [15:0] zz;
      L = 16 / kOf(sel);
      getOut(sel, rd, bs, dn, zz, bb, vv);
      checkOutput({tag, " ready"}, 32'(rd), 32'd1);
      applyStimulus(sel, 1'b1, md, xv, yv, bi);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(sel, 1'b0, ~md, ~xv, ~yv, ~bi);
      cycles  = 0;
      busyCnt = 0;
      for (;;) begin
         getOut(sel, rd, bs, dn, zz, bb, vv);
         if (dn || cycles >= 40) break;
         if (bs) busyCnt++;
         if (poke && cycles == 0) applyStimulus(sel, 1'b1, ~md, 16'hFFFF, 16'h0000, 1'b1);
         @(negedge clk);
         cycles++;
         if (poke && cycles == 1) applyStimulus(sel, 1'b0, md, xv, yv, bi);
      end
      checkOutput({tag, " latency"}, 32'(cycles), 32'(L));
      checkOutput({tag, " busy"}, 32'(busyCnt), 32'(L));
      checkOutput({tag, " z"}, 32'(zz), 32'(ez));
      checkOutput({tag, " b"}, 32'(bb), 32'(eb));
      checkOutput({tag, " v"}, 32'(vv), 32'(ev));
   endtask

   initial begin
      logic rd, bs, dn, bb, vv, sawDone;
      logic [15:0] zz;
      rst = 1'b1;
      for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, MODE_SUB, 16'h0, 16'h0, 1'b0);

      for (int sel = 0; sel < 3; sel++) begin
         curK = kOf(sel);
         $display("[TB] sequence for K=%0d", curK);

         rst = 1'b1;
         repeat (2) @(posedge clk);
         @(negedge clk);
         getOut(sel, rd, bs, dn, zz, bb, vv);
         checkOutput("rst ready", 32'(rd), 32'd1);
         checkOutput("rst busy", 32'(bs), 32'd0);
         checkOutput("rst done", 32'(dn), 32'd0);
         checkOutput("rst z", 32'(zz), 32'd0);
         checkOutput("rst b", 32'(bb), 32'd0);
         checkOutput("rst v", 32'(vv), 32'd0);
         rst = 1'b0;
         @(negedge clk);

         runOp(sel, "sub 5-3", MODE_SUB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         runOp(sel, "sub 0-1", MODE_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         runOp(sel, "sub 10-F-1", MODE_SUB, 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         runOp(sel, "sub ovf", MODE_SUB, 16'h8000, 16'h0001, 1'b0, EXP_SUB_OVF, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         runOp(sel, "add ovf", MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, EXP_ADD_OVF, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         runOp(sel, "add carry", MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         runOp(sel, "start ignored", MODE_SUB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
         @(negedge clk);

         // Second op is issued while the first is in DONE.
         runOp(sel, "b2b first", MODE_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
         runOp(sel, "b2b second", MODE_SUB, 16'h1234, 16'h4321, 1'b1, 16'hCF12, 1'b1, 1'b0, 1'b0);
         @(negedge clk);

         // Abort in the second RUN cycle (the only one when K=N), with start also asserted.
         applyStimulus(sel, 1'b1, MODE_ADD, 16'h7FFF, 16'h0001, 1'b0);
         @(posedge clk);
         @(negedge clk);
         applyStimulus(sel, 1'b0, MODE_ADD, 16'h7FFF, 16'h0001, 1'b0);
         if (16 / curK >= 2) @(negedge clk);
         rst = 1'b1;
         applyStimulus(sel, 1'b1, MODE_SUB, 16'h0005, 16'h0003, 1'b0);
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         applyStimulus(sel, 1'b0, MODE_SUB, 16'h0005, 16'h0003, 1'b0);
         getOut(sel, rd, bs, dn, zz, bb, vv);
         checkOutput("abort ready", 32'(rd), 32'd1);
         checkOutput("abort busy", 32'(bs), 32'd0);
         checkOutput("abort done", 32'(dn), 32'd0);
         checkOutput("abort z", 32'(zz), 32'd0);
         checkOutput("abort b", 32'(bb), 32'd0);
         checkOutput("abort v", 32'(vv), 32'd0);
         sawDone = 1'b0;
         repeat (20) begin
            @(negedge clk);
            getOut(sel, rd, bs, dn, zz, bb, vv);
            if (dn) sawDone = 1'b1;
         end
         checkOutput("abort no done", 32'(sawDone), 32'd0);

         runOp(sel, "fresh sub", MODE_SUB, 16'h1234, 16'h4321, 1'b1, 16'hCF12, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
